matrix_row_scanner: RTL and testbench

//  Reads the seven 7-bit playfield rows (vis_0..vis_6) produced by the Tetris datapath.

---
 rtl/matrix_row_scanner.sv | 184 ++++++++++++++++++
 tb/tb_matrix_row_scanner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/matrix_row_scanner.sv
// ---------------------------------------------------------------------------
// matrix_row_scanner
//   Row-multiplexed driver for a 7x7 LED matrix. It takes a whole-frame
//   snapshot of the playfield rows in a one-cycle LOAD state. It then drives
//   each row for DWELL cycles, with BLANK all-off cycles between rows. A board
//   update therefore never tears inside a frame.
//
//   Optional feature macro: BRIGHT_PWM_EN
//     Adds the brightness port. Column data is gated by a per-row PWM counter.
//     When the macro is undefined, columns run at full duty during DRIVE.
//
// Ports
//   clka         in   system clock, rising edge
//   restart_n    in   async active-low reset
//   vis_0..vis_6 in   playfield rows (bit c = column c lit)
//   vis_stable   in   rows are coherent; sampled only in LOAD
//   brightness   in   PWM duty select (BRIGHT_PWM_EN only)
//   row_sel      out  one-hot row enable, active high
//   col_drv      out  column data for the enabled row
//   row_idx      out  index of the row being scanned
//   frame_start  out  one-cycle pulse in the LOAD cycle of each frame
//
//   All outputs are registered. r_state names the state that the next rising
//   edge executes, and the outputs show what that edge produced.
//   ROWS must stay at 7 to match the vis_* port list.
// ---------------------------------------------------------------------------
module matrix_row_scanner #(
   parameter int ROWS     = 7,
   parameter int COLS     = 7,
   parameter int DWELL    = 16,
   parameter int BLANK    = 2,
   parameter int PWM_BITS = 3
) (
   input  logic                clka,
   input  logic                restart_n,
   input  logic [COLS-1:0]     vis_0,
   input  logic [COLS-1:0]     vis_1,
   input  logic [COLS-1:0]     vis_2,
   input  logic [COLS-1:0]     vis_3,
   input  logic [COLS-1:0]     vis_4,
   input  logic [COLS-1:0]     vis_5,
   input  logic [COLS-1:0]     vis_6,
   input  logic                vis_stable,
`ifdef BRIGHT_PWM_EN
   input  logic [PWM_BITS-1:0] brightness,
`endif
   output logic [ROWS-1:0]     row_sel,
   output logic [COLS-1:0]     col_drv,
   output logic [2:0]          row_idx,
   output logic                frame_start
);

   localparam int DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int BW         = (BLANK > 1) ? $clog2(BLANK) : 1;
   localparam int BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;

   typedef enum logic [1:0] {ST_LOAD, ST_DRIVE, ST_BLANK} state_t;

   state_t          r_state, w_state_nxt;
   logic [2:0]      r_row, w_row_nxt;
   logic [DW-1:0]   r_dwell, w_dwell_nxt;
   logic [BW-1:0]   r_blank, w_blank_nxt;
   logic [COLS-1:0] r_snap [ROWS];
   logic [COLS-1:0] w_vis  [ROWS];

   logic [ROWS-1:0] r_row_sel, w_row_sel_nxt;
   logic [COLS-1:0] r_col_drv, w_col_nxt;
   logic [2:0]      r_row_idx, w_row_idx_nxt;
   logic            r_fs, w_fs_nxt;
   logic            w_load, w_adv, w_gate, w_dwell_last;

   assign w_vis[0] = vis_0;
   assign w_vis[1] = vis_1;
   assign w_vis[2] = vis_2;
   assign w_vis[3] = vis_3;
   assign w_vis[4] = vis_4;
   assign w_vis[5] = vis_5;
   assign w_vis[6] = vis_6;

   assign w_dwell_last = (r_dwell == DW'(DWELL - 1));

`ifdef BRIGHT_PWM_EN
   logic [PWM_BITS-1:0] r_pwm, w_pwm_nxt;

   // The counter equals the dwell position modulo 2^PWM_BITS. It is zero on
   // the first DRIVE cycle of every row, including back-to-back rows when
   // BLANK=0.
   assign w_gate = (r_pwm < brightness);

   always_comb begin
      w_pwm_nxt = '0;
      if (r_state == ST_DRIVE && !w_dwell_last)
         w_pwm_nxt = r_pwm + 1'b1;
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) r_pwm <= '0;
      else            r_pwm <= w_pwm_nxt;
   end
`else
   assign w_gate = 1'b1;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_row_nxt     = r_row;
      w_dwell_nxt   = r_dwell;
      w_blank_nxt   = r_blank;
      w_row_sel_nxt = '0;
      w_col_nxt     = '0;
      w_row_idx_nxt = r_row;
      w_fs_nxt      = 1'b0;
      w_load        = 1'b0;
      w_adv         = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_fs_nxt      = 1'b1;
            w_row_idx_nxt = 3'd0;
            w_load        = vis_stable;
            w_row_nxt     = 3'd0;
            w_dwell_nxt   = '0;
            w_state_nxt   = ST_DRIVE;
         end
         ST_DRIVE: begin
            w_row_sel_nxt = ROWS'(1) << r_row;
            w_col_nxt     = w_gate ? r_snap[r_row] : '0;
            if (w_dwell_last) begin
               w_dwell_nxt = '0;
               w_blank_nxt = '0;
               if (BLANK == 0) w_adv = 1'b1;
               else            w_state_nxt = ST_BLANK;
            end else begin
               w_dwell_nxt = r_dwell + 1'b1;
            end
         end
         ST_BLANK: begin
            if (r_blank == BW'(BLANK_LAST)) w_adv = 1'b1;
            else                           w_blank_nxt = r_blank + 1'b1;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
      // Next-row decision: after the last row, go back to a fresh LOAD.
      if (w_adv) begin
         if (r_row == 3'(ROWS - 1)) begin
            w_row_nxt   = 3'd0;
            w_state_nxt = ST_LOAD;
         end else begin
            w_row_nxt   = r_row + 3'd1;
            w_state_nxt = ST_DRIVE;
         end
      end
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         r_state   <= ST_LOAD;
         r_row     <= '0;
         r_dwell   <= '0;
         r_blank   <= '0;
         r_row_sel <= '0;
         r_col_drv <= '0;
         r_row_idx <= '0;
         r_fs      <= 1'b0;
         for (int r = 0; r < ROWS; r++) r_snap[r] <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_row     <= w_row_nxt;
         r_dwell   <= w_dwell_nxt;
         r_blank   <= w_blank_nxt;
         r_row_sel <= w_row_sel_nxt;
         r_col_drv <= w_col_nxt;
         r_row_idx <= w_row_idx_nxt;
         r_fs      <= w_fs_nxt;
         if (w_load)
            for (int r = 0; r < ROWS; r++) r_snap[r] <= w_vis[r];
      end
   end

   assign row_sel     = r_row_sel;
   assign col_drv     = r_col_drv;
   assign row_idx     = r_row_idx;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// ---------------------------------------------------------------------------
// tb_matrix_row_scanner
//   Directed bench for the default build (DWELL=16, BLANK=2, no PWM).
//   Outputs are sampled on the falling edge, and inputs are changed there too.
// ---------------------------------------------------------------------------
module tb_matrix_row_scanner;

   logic             clka = 1'b0;
   logic             restart_n;
   logic [6:0][6:0]  vis;
   logic             vis_stable;
   logic [6:0]       row_sel;
   logic [6:0]       col_drv;
   logic [2:0]       row_idx;
   logic             frame_start;

   int n_vec = 0;
   int n_err = 0;

   always #5 clka = ~clka;

   matrix_row_scanner dut (
      .clka        (clka),
      .restart_n   (restart_n),
      .vis_0       (vis[0]),
      .vis_1       (vis[1]),
      .vis_2       (vis[2]),
      .vis_3       (vis[3]),
      .vis_4       (vis[4]),
      .vis_5       (vis[5]),
      .vis_6       (vis[6]),
      .vis_stable  (vis_stable),
      .row_sel     (row_sel),
      .col_drv     (col_drv),
      .row_idx     (row_idx),
      .frame_start (frame_start)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // The call is made at the falling edge where the LOAD output cycle is
   // visible. It checks one full frame and ends at the next LOAD cycle,
   // 127 cycles later. If chg_row >= 0, new inputs are applied at dwell 0 of
   // that row.
   task automatic scan_frame(input string fid, input logic [6:0][6:0] exp,
                             input int chg_row, input logic [6:0][6:0] nv,
                             input logic nst);
      logic [6:0] sel;
      chk({fid, "_ld_fs"},  32'(frame_start), 32'd1);
      chk({fid, "_ld_sel"}, 32'(row_sel),     32'd0);
      chk({fid, "_ld_col"}, 32'(col_drv),     32'd0);
      chk({fid, "_ld_idx"}, 32'(row_idx),     32'd0);
      for (int r = 0; r < 7; r++) begin
         sel = 7'h01 << r;
         for (int d = 0; d < 16; d++) begin
            @(negedge clka);
            chk($sformatf("%s_r%0d_d%0d_sel", fid, r, d), 32'(row_sel), 32'(sel));
            chk($sformatf("%s_r%0d_d%0d_col", fid, r, d), 32'(col_drv), 32'(exp[r]));
            chk($sformatf("%s_r%0d_d%0d_idx", fid, r, d), 32'(row_idx), 32'(r));
            chk($sformatf("%s_r%0d_d%0d_fs",  fid, r, d), 32'(frame_start), 32'd0);
            if (r == chg_row && d == 0) begin
               vis        = nv;
               vis_stable = nst;
            end
         end
         for (int b = 0; b < 2; b++) begin
            @(negedge clka);
            chk($sformatf("%s_r%0d_b%0d_sel", fid, r, b), 32'(row_sel), 32'd0);
            chk($sformatf("%s_r%0d_b%0d_col", fid, r, b), 32'(col_drv), 32'd0);
            chk($sformatf("%s_r%0d_b%0d_fs",  fid, r, b), 32'(frame_start), 32'd0);
         end
      end
      @(negedge clka);
   endtask

   logic [6:0][6:0] img_a, img_b, img_c, img_d, stim;

   initial begin
      img_a = '0; img_a[0] = 7'h55; img_a[6] = 7'h2A;
      img_b = img_a; img_b[0] = 7'h7F;
      img_c = img_b;
      img_d = img_b; img_d[6] = 7'h01;

      restart_n  = 1'b0;
      vis        = img_a;
      vis_stable = 1'b1;
      repeat (3) @(negedge clka);
      chk("rst_sel", 32'(row_sel),     32'd0);
      chk("rst_col", 32'(col_drv),     32'd0);
      chk("rst_idx", 32'(row_idx),     32'd0);
      chk("rst_fs",  32'(frame_start), 32'd0);

      // The first edge after release executes LOAD.
      restart_n = 1'b1;
      @(negedge clka);

      // Frame 1 scans image A. During row 6, vis_0 becomes 7F and vis_stable
      // drops, so the next LOAD must keep the old snapshot.
      stim = img_b;
      scan_frame("f1", img_a, 6, stim, 1'b0);
      // Frame 2 still shows 55 on row 0. vis_stable rises before the next LOAD.
      scan_frame("f2", img_a, 3, img_c, 1'b1);
      // Frame 3 shows 7F. vis_6 changes during row 2, which must not tear.
      scan_frame("f3", img_c, 2, img_d, 1'b1);
      // Frame 4 picks up vis_6 = 01.
      scan_frame("f4", img_d, -1, img_d, 1'b1);

      // Reset in the middle of row 3 DRIVE (dwell 5) of frame 5.
      repeat (3 * 18 + 6) @(negedge clka);
      chk("pre_rst_sel", 32'(row_sel), 32'h08);
      chk("pre_rst_col", 32'(col_drv), 32'd0);
      restart_n = 1'b0;
      #1;
      chk("async_rst_sel", 32'(row_sel), 32'd0);
      chk("async_rst_idx", 32'(row_idx), 32'd0);
      vis[3] = 7'h33;
      img_d[3] = 7'h33;
      @(negedge clka);
      chk("rst_hold_col", 32'(col_drv), 32'd0);
      restart_n = 1'b1;
      @(negedge clka);
      scan_frame("f6", img_d, -1, img_d, 1'b1);
      chk("f6_period_fs", 32'(frame_start), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

endmodule
